// File: rtl/dm_lane_responder_pkg.sv
// ----------------------------------------------------------------------------
// dm_lane_responder_pkg: byte-enable codes, FSM encodings, request decode helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dm_lane_responder_pkg;

  localparam logic [3:0] BE_W  = 4'b1111;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_W)  || (be == BE_H0) || (be == BE_H1) ||
           (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3);
  endfunction

  function automatic logic load_misaligned(input logic [1:0] lo, input logic lh, input logic lb);
    if (lb) return 1'b0;
    if (lh) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane_responder_if.sv
// ----------------------------------------------------------------------------
// dm_lane_responder_if: M-stage request / W-stage response bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dm_lane_responder_if;
  logic        ready;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  mem_write;
  logic        sh_slt;
  logic        sb_slt;
  logic        ld_en;
  logic        lh_slt;
  logic        lb_slt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;

  modport master (
    input  ready, rd_valid, rd_data, err,
    output req_valid, req_addr, req_wdata, mem_write,
           sh_slt, sb_slt, ld_en, lh_slt, lb_slt
  );

  modport slave (
    output ready, rd_valid, rd_data, err,
    input  req_valid, req_addr, req_wdata, mem_write,
           sh_slt, sb_slt, ld_en, lh_slt, lb_slt
  );
endinterface

`default_nettype wire

// File: rtl/dm_load_ext.sv
// ----------------------------------------------------------------------------
// dm_load_ext: combinational lane select and sign extension of a loaded word
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_load_ext (
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic        lh_slt_i,
  input  logic        lb_slt_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    if (lb_slt_i)      data_o = {{24{byte_sel[7]}}, byte_sel};
    else if (lh_slt_i) data_o = {{16{half_sel[15]}}, half_sel};
    else               data_o = word_i;
  end
endmodule

`default_nettype wire

// File: rtl/dm_lane_responder.sv
// ----------------------------------------------------------------------------
// dm_lane_responder: lane-masked data memory with post-reset clear sweep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_lane_responder
  import dm_lane_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_LSB   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_lane_responder_if.slave   bus
);
  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [31:0]           mem_q [WORDS];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept, is_store, is_load, st_legal, ld_bad;
  logic                  wr_en, ld_ok, err_d;
  logic [31:0]           lane_wdata, ext_data;

  logic [31:0]           word_q, hold_q;
  logic [1:0]            lo_q;
  logic                  lh_q, lb_q, pend_q, err_q;
  logic                  unused_addr;

  assign unused_addr = ^bus.req_addr[31:DEPTH_LOG2+ADDR_LSB];

  always_comb begin
    idx      = bus.req_addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB];
    accept   = (state_q == S_READY) && bus.req_valid;
    is_store = |bus.mem_write;
    is_load  = bus.ld_en && !is_store;
    st_legal = be_legal(bus.mem_write);
    ld_bad   = load_misaligned(bus.req_addr[1:0], bus.lh_slt, bus.lb_slt);
    wr_en    = accept && is_store && st_legal;
    ld_ok    = accept && is_load && !ld_bad;
    // A store carrying ld_en still writes, but the pairing is flagged
    err_d    = accept && ((is_store && (!st_legal || bus.ld_en)) || (is_load && ld_bad));

    if (bus.sb_slt)      lane_wdata = {4{bus.req_wdata[7:0]}};
    else if (bus.sh_slt) lane_wdata = {2{bus.req_wdata[15:0]}};
    else                 lane_wdata = bus.req_wdata;

    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      if (ptr_q == {DEPTH_LOG2{1'b1}}) state_d = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == S_CLEAR) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_en) begin
        if (bus.mem_write[0]) mem_q[idx][7:0]   <= lane_wdata[7:0];
        if (bus.mem_write[1]) mem_q[idx][15:8]  <= lane_wdata[15:8];
        if (bus.mem_write[2]) mem_q[idx][23:16] <= lane_wdata[23:16];
        if (bus.mem_write[3]) mem_q[idx][31:24] <= lane_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      word_q <= mem_q[idx];
      lo_q   <= bus.req_addr[1:0];
      lh_q   <= bus.lh_slt;
      lb_q   <= bus.lb_slt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= ld_ok;
      err_q   <= err_d;
      if (pend_q) hold_q <= ext_data;
    end
  end

  dm_load_ext u_ext (
    .word_i   (word_q),
    .addr_i   (lo_q),
    .lh_slt_i (lh_q),
    .lb_slt_i (lb_q),
    .data_o   (ext_data)
  );

  assign bus.ready    = (state_q == S_READY);
  assign bus.rd_valid = pend_q;
  assign bus.rd_data  = pend_q ? ext_data : hold_q;
  assign bus.err      = err_q;
endmodule

`default_nettype wire

// File: tb/tb_dm_lane_responder.sv
// ----------------------------------------------------------------------------
// tb_dm_lane_responder: directed and randomized checks against a byte-array model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dm_lane_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_lane_responder_if bus ();

  dm_lane_responder #(.DEPTH_LOG2(10), .ADDR_LSB(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [4096];
  logic [31:0] exp_hold;
  logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       input logic sh, input logic sb, input logic ld, input logic lh, input logic lb);
    bus.req_valid = v;  bus.req_addr = a;  bus.req_wdata = w;  bus.mem_write = be;
    bus.sh_slt = sh;    bus.sb_slt = sb;   bus.ld_en = ld;     bus.lh_slt = lh;  bus.lb_slt = lb;
  endtask

  function automatic logic is_legal(input logic [3:0] be);
    for (int i = 0; i < 7; i++) if (legal_be[i] == be) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one request for a cycle and compare the outputs against the model
  task automatic req(input string tag, input logic v, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] be, input logic sh, input logic sb, input logic ld,
                     input logic lh, input logic lb);
    logic        e_err, e_rv;
    int          base, off;
    logic [7:0]  bt;
    logic [15:0] hw;
    logic [31:0] val;
    e_err = 1'b0;
    e_rv  = 1'b0;
    val   = '0;
    base  = int'({a[11:2], 2'b00});
    off   = int'(a[1:0]);
    drive(v, a, w, be, sh, sb, ld, lh, lb);
    if (v) begin
      if (be != 4'b0000) begin
        e_err = !is_legal(be) || ld;
        if (is_legal(be)) begin
          for (int b = 0; b < 4; b++) begin
            if (sb)      bt = w[7:0];
            else if (sh) bt = (b % 2 == 1) ? w[15:8] : w[7:0];
            else         bt = w[8*b +: 8];
            if (be[b]) mdl[base + b] = bt;
          end
        end
      end else if (ld) begin
        if (lb) begin
          bt  = mdl[base + off];
          val = {{24{bt[7]}}, bt};
        end else if (lh) begin
          e_err = a[0];
          hw    = {mdl[base + (off & 2) + 1], mdl[base + (off & 2)]};
          val   = {{16{hw[15]}}, hw};
        end else begin
          e_err = (a[1:0] != 2'b00);
          val   = {mdl[base + 3], mdl[base + 2], mdl[base + 1], mdl[base]};
        end
        if (!e_err) begin
          e_rv     = 1'b1;
          exp_hold = val;
        end
      end
    end
    step();
    chk({tag, ".rd_valid"}, {31'b0, bus.rd_valid}, {31'b0, e_rv});
    chk({tag, ".err"},      {31'b0, bus.err},      {31'b0, e_err});
    chk({tag, ".rd_data"},  bus.rd_data,           exp_hold);
  endtask

  initial begin
    int          n;
    int          k;
    logic [31:0] a;
    logic [3:0]  be;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    exp_hold = '0;

    step(); step();
    chk("rst.ready",    {31'b0, bus.ready},    0);
    chk("rst.rd_valid", {31'b0, bus.rd_valid}, 0);
    chk("rst.err",      {31'b0, bus.err},      0);
    chk("rst.rd_data",  bus.rd_data,           0);

    reset = 1'b1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      n++;
      step();
    end
    chk("sweep_len", n, 1024);

    req("lw_ffc", 1, 32'h0000_0FFC, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("lw_ffc.lit", bus.rd_data, 32'h0000_0000);

    req("sw10", 1, 32'h10, 32'h8765_4321, 4'b1111, 0, 0, 0, 0, 0);
    req("lh12", 1, 32'h12, 0, 4'b0000, 0, 0, 1, 1, 0);
    chk("lh12.lit", bus.rd_data, 32'hFFFF_8765);
    req("lh10", 1, 32'h10, 0, 4'b0000, 0, 0, 1, 1, 0);
    chk("lh10.lit", bus.rd_data, 32'h0000_4321);

    req("sb21", 1, 32'h21, 32'h0000_00AB, 4'b0010, 0, 1, 0, 0, 0);
    req("lw20", 1, 32'h20, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("lw20.lit", bus.rd_data, 32'h0000_AB00);
    req("lb21", 1, 32'h21, 0, 4'b0000, 0, 0, 1, 0, 1);
    chk("lb21.lit", bus.rd_data, 32'hFFFF_FFAB);

    req("sw30",   1, 32'h30, 32'h1122_3344, 4'b1111, 0, 0, 0, 0, 0);
    req("be0101", 1, 32'h30, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, 0, 0);
    req("lw30",   1, 32'h30, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("lw30.lit", bus.rd_data, 32'h1122_3344);
    req("lw31",   1, 32'h31, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("lw31.hold", bus.rd_data, 32'h1122_3344);

    req("b2b.sw40", 1, 32'h40, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 0, 0);
    req("b2b.lw40", 1, 32'h40, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("b2b.lw40.lit", bus.rd_data, 32'hCAFE_F00D);
    req("b2b.lw44", 1, 32'h44, 0, 4'b0000, 0, 0, 1, 0, 0);
    req("idle", 1, 32'h44, 0, 4'b0000, 0, 0, 0, 0, 0);

    req("st_and_ld", 1, 32'h800, 32'h0, 4'b1111, 0, 0, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 511));
      if (k <= 3) begin
        n = $urandom_range(0, 8);
        if (n < 7) be = legal_be[n];
        else       be = 4'($urandom_range(1, 15));
        req("rnd.st", 1, a, $urandom, be,
            (be == 4'b0011 || be == 4'b1100), (be == 4'b0001 || be == 4'b0010 ||
             be == 4'b0100 || be == 4'b1000), 0, 0, 0);
      end else if (k <= 7) begin
        n = $urandom_range(0, 2);
        req("rnd.ld", 1, a, 0, 4'b0000, 0, 0, 1, (n == 1), (n == 2));
      end else if (k == 8) begin
        req("rnd.novalid", 0, a, $urandom, 4'b1111, 0, 0, 0, 0, 0);
      end else begin
        req("rnd.noop", 1, a, $urandom, 4'b0000, 0, 0, 0, 0, 0);
      end
    end

    // Load accepted, then reset on the following edge: no trailing pulse
    req("pre_rst.lw", 1, 32'h40, 0, 4'b0000, 0, 0, 1, 0, 0);
    reset = 1'b0;
    step();
    chk("rst2.rd_valid", {31'b0, bus.rd_valid}, 0);
    chk("rst2.ready",    {31'b0, bus.ready},    0);
    chk("rst2.rd_data",  bus.rd_data,           0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    exp_hold = '0;
    reset = 1'b1;
    for (int i = 0; i < 500; i++) step();
    chk("mid.ready", {31'b0, bus.ready}, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      if (n == 600) drive(1, 32'h50, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0, 0);
      else          drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n++;
      step();
      if (n == 601) chk("clr_store.err", {31'b0, bus.err}, 0);
    end
    chk("sweep2_len", n, 1024);
    req("lw50", 1, 32'h50, 0, 4'b0000, 0, 0, 1, 0, 0);
    chk("lw50.lit", bus.rd_data, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/dm_lane_responder.md
Name: dm_lane_responder

Overview:
- Data-memory responder on the M-stage side of the load/store path.
- Consumes the 4-bit byte-enable and the lh/lb select strobes that the M-stage controller produces.
- Performs lane-masked writes and returns registered, sign-extended load data into the W stage.
- Owns a post-reset clear sweep, so the memory contents are defined before the pipeline issues requests.

Parameters:
- DEPTH_LOG2, 10, number of word-address bits; the array holds 2^DEPTH_LOG2 32-bit words.
- ADDR_LSB, 2, byte-offset bits; fixed at 2 for 32-bit words and exposed only for clarity.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- ready  out  1  1 when the block accepts requests; 0 during the clear sweep.
- req_valid  in  1  request strobe for this cycle.
- req_addr  in  32  byte address; bits [DEPTH_LOG2+1:2] index the word, bits [1:0] select the lane.
- req_wdata  in  32  raw rt value, not lane-shifted.
- mem_write  in  4  byte enables from the M-stage controller.
- sh_slt  in  1  current store is sh.
- sb_slt  in  1  current store is sb.
- ld_en  in  1  current instruction is lw, lh or lb.
- lh_slt  in  1  current load is lh.
- lb_slt  in  1  current load is lb.
- rd_valid  out  1  1-cycle pulse, one cycle after an accepted load.
- rd_data  out  32  extended load result; holds its last value when rd_valid = 0.
- err  out  1  1-cycle pulse, one cycle after a rejected (illegal) request.

Behaviour:
- Reset (reset = 0 at an edge):
  - ready = 0, rd_valid = 0, rd_data = 0, err = 0.
  - The clear pointer is set to 0 and the state goes to CLEAR.
  - Reset asserted during CLEAR restarts the sweep at 0.
  - Reset asserted during READY discards any in-flight load; no rd_valid is produced for it.
- FSM, two states:
  - CLEAR: each cycle, mem[ptr] <= 0 and ptr <= ptr + 1. When ptr = 2^DEPTH_LOG2 - 1, the state moves to READY on that same edge. The sweep takes exactly 2^DEPTH_LOG2 cycles.
  - READY: ready = 1. The block stays in READY until the next reset.
- Request acceptance:
  - A request is accepted only when ready = 1 and req_valid = 1.
  - In CLEAR, requests are ignored silently: no write, no rd_valid, no err.
- Store (mem_write != 0):
  - Lane data is replicated from req_wdata:
    - sb_slt = 1: all four lanes get req_wdata[7:0].
    - sh_slt = 1: both halves get req_wdata[15:0].
    - otherwise: req_wdata as-is.
  - Only the bytes enabled in mem_write are written, at the clk edge.
  - Legal mem_write patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other pattern causes no write and an err pulse on the next cycle.
  - Address bits above DEPTH_LOG2+1 are ignored (the address wraps modulo the array size).
- Load (ld_en = 1 and mem_write = 0):
  - The word read and the request attributes are captured at the edge.
  - On the next cycle, rd_valid = 1 and rd_data is:
    - lb_slt = 1: the byte at addr[1:0], sign-extended.
    - lh_slt = 1: the halfword at addr[1], sign-extended.
    - otherwise: the full word.
  - Misaligned loads are rejected: lw with addr[1:0] != 00, or lh with addr[0] = 1. A rejected load gives err = 1, rd_valid = 0, and rd_data is unchanged.
- Simultaneous store and load (mem_write != 0 and ld_en = 1):
  - The store wins and the load is dropped.
  - err pulses, because the controller never drives both.
- Read-after-write ordering: a load in cycle N+1 to an address stored in cycle N returns the new data (the write completes at edge N).
- Latency: stores take effect at the accepting edge; load data is valid exactly 1 cycle after acceptance; back-to-back loads give back-to-back rd_valid pulses.
- Idle cycles: req_valid = 0, or ld_en = 0 with mem_write = 0, causes no state change and no pulses.

Decomposition:
- Shared package/header (alongside the existing opcode defines):
  - byte-enable constants BE_W = 4'b1111, BE_H0 = 4'b0011, BE_H1 = 4'b1100, BE_B0..BE_B3;
  - FSM state encodings S_CLEAR, S_READY.
- One natural sub-module: dm_load_ext, a purely combinational lane select and sign extension (inputs: word, addr[1:0], lh_slt, lb_slt). It is instantiated after the read register and is reused by W-stage forwarding checks.

Test Plan:
- Reset sweep: hold reset = 0 for 2 cycles, then release. Required: ready = 0 for exactly 1024 cycles, then 1. A lw from 0x0000_0FFC returns 0x0000_0000 with rd_valid one cycle later.
- Store-word then halfword load: sw 0x8765_4321 to 0x10, then next cycle lh at 0x12. Required: rd_data = 0xFFFF_8765. Then lh at 0x10: rd_data = 0x0000_4321.
- Byte lanes: sb req_wdata = 0x0000_00AB at 0x21 (mem_write 0010) onto a zeroed word, then lw at 0x20. Required: rd_data = 0x0000_AB00. Then lb at 0x21: rd_data = 0xFFFF_FFAB.
- Illegal requests:
  - mem_write = 0101 to 0x30: err pulses, memory unchanged (lw 0x30 returns its prior value).
  - lw at 0x31: err = 1, rd_valid = 0, rd_data holds its previous value.
- Reset mid-sweep: drive reset = 0 at clear cycle 500, then release. Required: ready stays 0 for a further full 1024 cycles, and a store issued during CLEAR has no effect.
- Back-to-back traffic: sw to 0x40, lw 0x40, lw 0x44 on consecutive cycles. Required: two consecutive rd_valid pulses, the first returning the new data.
